rim_job_sched: RTL and testbench

- Shares one rat-in-a-maze solver (8x8 maze, entrance row 0/col 7, exit row 7/col 0, rows loaded 8 bits/cycle, path reported one cell per cycle on out_valid) between N_REQ requesters.
- Arbitrates round-robin, pre-checks the maze, resets and loads the solver, then forwards the path back to the winning requester.
- A timeout guards against a solver that never answers.
- Sits between the requester fabric and a single solver instance.

---
 rtl/rim_job_sched_pkg.sv | 39 +++
 rtl/rim_job_sched_if.sv | 30 +++
 rtl/rim_job_sched_rr_arb.sv | 36 +++
 rtl/rim_job_sched.sv | 212 +++++++++++++++++++++
 tb/tb_rim_job_sched.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rim_job_sched_pkg.sv
// Shared types and maze geometry for the rat-in-a-maze job scheduler.
package rim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_SRST,
        ST_LOAD,
        ST_GAP,
        ST_WAIT,
        ST_STREAM,
        ST_FLUSH
    } state_t;

    localparam int unsigned MAZE_DIM  = 32'd8;
    localparam int unsigned ENTRY_ROW = 32'd0;
    localparam int unsigned ENTRY_COL = 32'd7;
    localparam int unsigned EXIT_ROW  = 32'd7;
    localparam int unsigned EXIT_COL  = 32'd0;

    typedef struct packed {
        logic [2:0] row;
        logic [2:0] col;
    } cell_t;

    function automatic int unsigned id_w(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

    function automatic logic [7:0] maze_row(input logic [63:0] m, input logic [2:0] r);
        return m[{r, 3'b000} +: 8];
    endfunction

    // A job is only worth loading when both the entrance and the exit cell are open.
    function automatic logic path_open(input logic [63:0] m);
        return m[ENTRY_ROW*MAZE_DIM + ENTRY_COL] & m[EXIT_ROW*MAZE_DIM + EXIT_COL];
    endfunction

endpackage

// File: rtl/rim_job_sched_if.sv
// Requester-side bus of the scheduler: job requests in, path responses out.
interface rim_job_sched_if #(
    parameter int N_REQ = 2
);
    import rim_pkg::*;

    localparam int IW = int'(id_w(N_REQ));

    logic [N_REQ-1:0]    req_valid;
    logic [64*N_REQ-1:0] req_maze;
    logic [N_REQ-1:0]    req_ack;
    logic                rsp_valid;
    logic [IW-1:0]       rsp_id;
    logic [2:0]          rsp_row;
    logic [2:0]          rsp_col;
    logic                rsp_last;
    logic                rsp_fail;
    logic                busy;

    modport master (
        output req_valid, req_maze,
        input  req_ack, rsp_valid, rsp_id, rsp_row, rsp_col, rsp_last, rsp_fail, busy
    );

    modport slave (
        input  req_valid, req_maze,
        output req_ack, rsp_valid, rsp_id, rsp_row, rsp_col, rsp_last, rsp_fail, busy
    );

endinterface

// File: rtl/rim_job_sched_rr_arb.sv
// Round-robin pick: first requester at or after ptr, wrapping to index 0.
module rim_rr_arb
    import rim_pkg::*;
#(
    parameter int N_REQ = 2,
    localparam int IW = int'(id_w(N_REQ))
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             any,
    output logic [IW-1:0]    idx
);

    // Two ordered scans: upper segment [ptr..N-1] first, then the wrap from 0.
    always_comb begin
        any = 1'b0;
        idx = IW'(0);
        for (int j = 0; j < N_REQ; j++) begin
            if (!any && req[j] && (IW'(j) >= ptr)) begin
                any = 1'b1;
                idx = IW'(j);
            end else begin
                idx = idx;
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!any && req[j]) begin
                any = 1'b1;
                idx = IW'(j);
            end else begin
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/rim_job_sched.sv
// Shares one maze solver between N_REQ requesters: arbitrate, precheck, load,
// then forward the solver path (one beat per cell) to the winning requester.
module rim_job_sched
    import rim_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 1024,
    parameter int MAX_STEPS   = 15
) (
    input  logic            clk,
    input  logic            rst,
    rim_job_sched_if.slave  bus,
    output logic            slv_rst_n,
    output logic            slv_in_valid,
    output logic [7:0]      slv_maze,
    input  logic            slv_out_valid,
    input  logic [2:0]      slv_out_row,
    input  logic [2:0]      slv_out_col
);

    localparam int IW = int'(id_w(N_REQ));
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int SW = $clog2(MAX_STEPS + 1);

    state_t           st_r, st_s;
    logic [IW-1:0]    ptr_r, ptr_s;
    logic [IW-1:0]    gnt_r, gnt_s;
    logic [63:0]      maze_r, maze_s;
    logic [2:0]       ld_r, ld_s;
    logic [TW-1:0]    to_r, to_s;
    logic [SW-1:0]    steps_r, steps_s;
    cell_t            hold_r, hold_s;
    logic [N_REQ-1:0] ack_r, ack_s;
    logic             slv_rst_n_r, slv_rst_n_s;
    logic             in_valid_r, in_valid_s;
    logic [7:0]       slv_maze_r, slv_maze_s;
    logic             rsp_valid_r, rsp_valid_s;
    logic [IW-1:0]    rsp_id_r, rsp_id_s;
    cell_t            rsp_cell_r, rsp_cell_s;
    logic             rsp_last_r, rsp_last_s;
    logic             rsp_fail_r, rsp_fail_s;
    logic             busy_r, busy_s;
    logic             arb_any_s;
    logic [IW-1:0]    arb_idx_s;

    rim_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .req (bus.req_valid),
        .ptr (ptr_r),
        .any (arb_any_s),
        .idx (arb_idx_s)
    );

    // State, datapath and output registers; every output is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_r        <= ST_IDLE;
            ptr_r       <= IW'(0);
            gnt_r       <= IW'(0);
            maze_r      <= 64'd0;
            ld_r        <= 3'd0;
            to_r        <= TW'(0);
            steps_r     <= SW'(0);
            hold_r      <= 6'd0;
            ack_r       <= N_REQ'(1'b0);
            slv_rst_n_r <= 1'b0;
            in_valid_r  <= 1'b0;
            slv_maze_r  <= 8'd0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= IW'(0);
            rsp_cell_r  <= 6'd0;
            rsp_last_r  <= 1'b0;
            rsp_fail_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            st_r        <= st_s;
            ptr_r       <= ptr_s;
            gnt_r       <= gnt_s;
            maze_r      <= maze_s;
            ld_r        <= ld_s;
            to_r        <= to_s;
            steps_r     <= steps_s;
            hold_r      <= hold_s;
            ack_r       <= ack_s;
            slv_rst_n_r <= slv_rst_n_s;
            in_valid_r  <= in_valid_s;
            slv_maze_r  <= slv_maze_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_id_r    <= rsp_id_s;
            rsp_cell_r  <= rsp_cell_s;
            rsp_last_r  <= rsp_last_s;
            rsp_fail_r  <= rsp_fail_s;
            busy_r      <= busy_s;
        end
    end

    // Next state plus the output values that become visible in that next state.
    always_comb begin
        st_s        = st_r;
        ptr_s       = ptr_r;
        gnt_s       = gnt_r;
        maze_s      = maze_r;
        ld_s        = ld_r;
        to_s        = to_r;
        steps_s     = steps_r;
        hold_s      = hold_r;
        ack_s       = N_REQ'(1'b0);
        slv_rst_n_s = 1'b1;
        in_valid_s  = 1'b0;
        slv_maze_s  = 8'd0;
        rsp_valid_s = 1'b0;
        rsp_id_s    = IW'(0);
        rsp_cell_s  = 6'd0;
        rsp_last_s  = 1'b0;
        rsp_fail_s  = 1'b0;

        case (st_r)
            ST_IDLE: begin
                if (arb_any_s) begin
                    st_s   = ST_GRANT;
                    gnt_s  = arb_idx_s;
                    maze_s = bus.req_maze[{arb_idx_s, 6'b000000} +: 64];
                    ack_s  = N_REQ'(1'b1) << arb_idx_s;
                end else begin
                    st_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                ptr_s = (gnt_r == IW'(N_REQ - 1)) ? IW'(0) : IW'(gnt_r + 1'b1);
                if (!path_open(maze_r)) begin
                    st_s        = ST_FLUSH;
                    rsp_valid_s = 1'b1;
                    rsp_id_s    = gnt_r;
                    rsp_last_s  = 1'b1;
                    rsp_fail_s  = 1'b1;
                end else begin
                    st_s        = ST_SRST;
                    slv_rst_n_s = 1'b0;
                end
            end
            ST_SRST: begin
                st_s       = ST_LOAD;
                ld_s       = 3'd0;
                in_valid_s = 1'b1;
                slv_maze_s = maze_row(maze_r, 3'd0);
            end
            ST_LOAD: begin
                if (ld_r == 3'd7) begin
                    st_s = ST_GAP;
                end else begin
                    ld_s       = ld_r + 3'd1;
                    in_valid_s = 1'b1;
                    slv_maze_s = maze_row(maze_r, ld_r + 3'd1);
                end
            end
            ST_GAP: begin
                st_s = ST_WAIT;
                to_s = TW'(0);
            end
            ST_WAIT: begin
                if (slv_out_valid) begin
                    st_s       = ST_STREAM;
                    hold_s.row = slv_out_row;
                    hold_s.col = slv_out_col;
                    steps_s    = SW'(1);
                end else if (to_r == TW'(TIMEOUT_CYC - 1)) begin
                    st_s        = ST_FLUSH;
                    rsp_valid_s = 1'b1;
                    rsp_id_s    = gnt_r;
                    rsp_last_s  = 1'b1;
                    rsp_fail_s  = 1'b1;
                end else begin
                    to_s = to_r + TW'(1);
                end
            end
            ST_STREAM: begin
                // The held cell is only known to be non-final once another strobe arrives.
                rsp_valid_s = 1'b1;
                rsp_id_s    = gnt_r;
                rsp_cell_s  = hold_r;
                if (slv_out_valid && (steps_r != SW'(MAX_STEPS))) begin
                    hold_s.row = slv_out_row;
                    hold_s.col = slv_out_col;
                    steps_s    = steps_r + SW'(1);
                end else begin
                    st_s       = ST_FLUSH;
                    rsp_last_s = 1'b1;
                end
            end
            ST_FLUSH: begin
                st_s = ST_IDLE;
            end
            default: begin
                st_s = ST_IDLE;
            end
        endcase

        busy_s = (st_s != ST_IDLE);
    end

    assign bus.req_ack   = ack_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_row   = rsp_cell_r.row;
    assign bus.rsp_col   = rsp_cell_r.col;
    assign bus.rsp_last  = rsp_last_r;
    assign bus.rsp_fail  = rsp_fail_r;
    assign bus.busy      = busy_r;
    assign slv_rst_n     = slv_rst_n_r;
    assign slv_in_valid  = in_valid_r;
    assign slv_maze      = slv_maze_r;

endmodule

// File: tb/tb_rim_job_sched.sv
// Scoreboard bench for rim_job_sched: expected acks and response beats are queued
// as jobs are issued and popped by a monitor as the scheduler produces them.
module tb_rim_job_sched;

    localparam int NR  = 2;
    localparam int TO  = 16;
    localparam int MAX = 15;

    typedef struct packed {
        logic       id;
        logic [2:0] row;
        logic [2:0] col;
        logic       last;
        logic       fail;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic slv_rst_n, slv_in_valid, slv_out_valid;
    logic [7:0] slv_maze;
    logic [2:0] slv_out_row, slv_out_col;

    int err_cnt = 0;
    int chk_cnt = 0;
    int beat_cnt = 0;
    int extra_cnt = 0;
    int in_valid_cnt = 0;
    exp_t exp_q[$];
    int   ack_q[$];
    exp_t mon_e;
    int   mon_a;

    always #5 clk = ~clk;

    rim_job_sched_if #(.N_REQ(NR)) bus();

    rim_job_sched #(.N_REQ(NR), .TIMEOUT_CYC(TO), .MAX_STEPS(MAX)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .slv_rst_n     (slv_rst_n),
        .slv_in_valid  (slv_in_valid),
        .slv_maze      (slv_maze),
        .slv_out_valid (slv_out_valid),
        .slv_out_row   (slv_out_row),
        .slv_out_col   (slv_out_col)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Straight path down column 7 then along row 7; later indices are filler cells.
    function automatic logic [5:0] cell_at(input int i);
        int r, c;
        if (i < 8) begin r = i; c = 7; end
        else if (i < 15) begin r = 7; c = 14 - i; end
        else begin r = i % 8; c = (i * 3) % 8; end
        return {3'(r), 3'(c)};
    endfunction

    // Scoreboard monitor: every ack and response beat is matched against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rsp_valid) begin
                beat_cnt++;
                if (exp_q.size() == 0) extra_cnt++;
                else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_beat", {bus.rsp_id, bus.rsp_row, bus.rsp_col, bus.rsp_last, bus.rsp_fail},
                        mon_e);
                end
            end
            if (bus.req_ack != '0) begin
                if (ack_q.size() == 0) extra_cnt++;
                else begin
                    mon_a = ack_q.pop_front();
                    chk("ack_vec", bus.req_ack, 64'd1 << mon_a);
                end
            end
            if (slv_in_valid) in_valid_cnt++;
        end
    end

    task automatic wait_ack(input int id);
        for (int n = 0; n < 100 && !bus.req_ack[id]; n++) tick();
        chk("ack_seen", bus.req_ack[id], 1'b1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200 && bus.busy; n++) tick();
        chk("idle_reached", bus.busy, 1'b0);
    endtask

    task automatic check_load(input logic [63:0] m);
        tick();
        chk("srst_rst_n", slv_rst_n, 1'b0);
        chk("srst_inv", slv_in_valid, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("load_row", {slv_rst_n, slv_in_valid, slv_maze}, {2'b11, m[k*8 +: 8]});
        end
        tick();
        chk("gap", {slv_in_valid, slv_maze}, 9'd0);
    endtask

    task automatic push_beats(input int id, input int nb);
        exp_t e;
        for (int i = 0; i < nb; i++) begin
            e.id = 1'(id);
            {e.row, e.col} = cell_at(i);
            e.last = (i == nb - 1);
            e.fail = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_fail(input int id);
        exp_t e;
        e.id = 1'(id); e.row = 3'd0; e.col = 3'd0; e.last = 1'b1; e.fail = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic run_job(input int id, input logic [63:0] m, input int n);
        int nb, b0;
        nb = (n < MAX) ? n : MAX;
        ack_q.push_back(id);
        push_beats(id, nb);
        b0 = beat_cnt;
        wait_ack(id);
        bus.req_valid[id] = 1'b0;
        check_load(m);
        tick();
        for (int i = 0; i < n; i++) begin
            slv_out_valid = 1'b1;
            {slv_out_row, slv_out_col} = cell_at(i);
            tick();
        end
        slv_out_valid = 1'b0;
        if (n <= MAX) begin
            tick();
            chk("last_latency", {bus.rsp_valid, bus.rsp_last}, 2'b11);
        end
        wait_idle();
        chk("beat_count", beat_cnt - b0, nb);
    endtask

    logic [63:0] m_ok, m_blk;
    int ic;

    initial begin
        m_ok  = {8'hFF, {7{8'h80}}};
        m_blk = {{7{8'hFF}}, 8'h7F};
        bus.req_valid = '0;
        bus.req_maze  = '0;
        slv_out_valid = 1'b0;
        slv_out_row   = 3'd0;
        slv_out_col   = 3'd0;

        tick(); tick();
        chk("rst_outs", {bus.busy, slv_rst_n, bus.req_ack, bus.rsp_valid, slv_in_valid, slv_maze},
            64'd0);
        rst = 1'b0;
        tick();
        chk("idle_rst_n", {slv_rst_n, bus.busy}, 2'b10);

        // Two simultaneous requesters, two rounds: grants go 0,1,0,1.
        bus.req_maze = {m_ok, m_ok};
        for (int r = 0; r < 2; r++) begin
            bus.req_valid = 2'b11;
            run_job(0, m_ok, 15);
            run_job(1, m_ok, 5);
        end

        // Single requester, full straight path.
        bus.req_valid = 2'b01;
        run_job(0, m_ok, 15);

        // Blocked entrance: fail beat right after ack, solver never loaded.
        bus.req_maze[127:64] = m_blk;
        bus.req_valid[1] = 1'b1;
        ack_q.push_back(1);
        push_fail(1);
        ic = in_valid_cnt;
        wait_ack(1);
        bus.req_valid[1] = 1'b0;
        tick();
        chk("precheck_fail", {bus.rsp_valid, bus.rsp_fail, bus.rsp_last, bus.rsp_row, bus.rsp_col},
            9'b111_000_000);
        wait_idle();
        chk("no_load", in_valid_cnt - ic, 0);

        // Silent solver: 16 WAIT cycles then a fail beat, idle one cycle later.
        bus.req_valid[0] = 1'b1;
        ack_q.push_back(0);
        push_fail(0);
        wait_ack(0);
        bus.req_valid[0] = 1'b0;
        check_load(m_ok);
        for (int i = 0; i < TO; i++) begin
            tick();
            chk("wait_quiet", {bus.busy, bus.rsp_valid}, 2'b10);
        end
        tick();
        chk("timeout_beat", {bus.rsp_valid, bus.rsp_fail, bus.rsp_last}, 3'b111);
        tick();
        chk("busy_drop", bus.busy, 1'b0);

        // Solver overruns: only MAX_STEPS beats, then the next job still runs.
        bus.req_maze[127:64] = m_ok;
        bus.req_valid[1] = 1'b1;
        run_job(1, m_ok, 20);
        bus.req_valid[0] = 1'b1;
        run_job(0, m_ok, 3);

        // Reset in the middle of LOAD row 4; pointer returns to requester 0.
        bus.req_valid = 2'b11;
        ack_q.push_back(1);
        wait_ack(1);
        for (int i = 0; i < 6; i++) tick();
        chk("pre_rst_row4", {slv_in_valid, slv_maze}, {1'b1, m_ok[39:32]});
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {bus.busy, slv_rst_n, slv_in_valid, slv_maze, bus.req_ack,
                             bus.rsp_valid, bus.rsp_last, bus.rsp_fail}, 64'd0);
        tick(); tick();
        rst = 1'b0;
        run_job(0, m_ok, 2);
        run_job(1, m_ok, 1);

        chk("rsp_extra", extra_cnt, 0);
        chk("rsp_missing", exp_q.size(), 0);
        chk("ack_missing", ack_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
